keyboard_transmitter: RTL and testbench

Host-to-device PS/2 transmitter for the keyboard controller. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the keyboard over the open-drain PS/2 CLK/DATA lines. The frame is start bit, 8 data bits LSB-first, odd parity, stop bit, then the device ACK bit. The CLK/DATA inputs come from the existing keyboard input synchronizer, so they are already 2-FF synchronized to iCLOCK.

---
 rtl/keyboard_transmitter.sv | 164 ++++++++++++++++
 tb/tb_keyboard_transmitter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the bus, then shifts out start, 8 data bits,
// odd parity and stop on device-generated clock falling edges, and checks the device ACK.
module keyboard_transmitter #(
    parameter int unsigned P_INHIBIT_CYCLES = 5000,
    parameter int unsigned P_TIMEOUT_CYCLES = 750000
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic       iREQ,
    input  logic [7:0] iDATA,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERROR,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE
);

    localparam int unsigned InhW  = (P_INHIBIT_CYCLES > 1) ? $clog2(P_INHIBIT_CYCLES) : 1;
    localparam int unsigned TimeW = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StInhibit, StStart, StXfer, StAck, StWaitIdle, StDone, StError
    } state_e;

    state_e            state_q;
    logic [9:0]        shift_q;
    logic [3:0]        bit_cnt_q;
    logic [InhW-1:0]   inh_cnt_q;
    logic [TimeW-1:0]  to_cnt_q;
    logic              ack_q;
    logic              clk_prev_q;

    logic fe;
    logic to_hit;

    assign fe     = clk_prev_q & ~iPS2_CLK;
    assign to_hit = (to_cnt_q == TimeW'(P_TIMEOUT_CYCLES - 1));

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            inh_cnt_q    <= '0;
            to_cnt_q     <= '0;
            ack_q        <= 1'b0;
            clk_prev_q   <= 1'b1;
            oBUSY        <= 1'b0;
            oDONE        <= 1'b0;
            oERROR       <= 1'b0;
            oPS2_CLK_OE  <= 1'b0;
            oPS2_DATA_OE <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            inh_cnt_q    <= '0;
            to_cnt_q     <= '0;
            ack_q        <= 1'b0;
            clk_prev_q   <= 1'b1;
            oBUSY        <= 1'b0;
            oDONE        <= 1'b0;
            oERROR       <= 1'b0;
            oPS2_CLK_OE  <= 1'b0;
            oPS2_DATA_OE <= 1'b0;
        end else begin
            clk_prev_q <= iPS2_CLK;
            case (state_q)
                StIdle: begin
                    if (iREQ) begin
                        shift_q     <= {1'b1, ~^iDATA, iDATA};
                        inh_cnt_q   <= '0;
                        oBUSY       <= 1'b1;
                        oPS2_CLK_OE <= 1'b1;
                        state_q     <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (inh_cnt_q == InhW'(P_INHIBIT_CYCLES - 1)) begin
                        oPS2_CLK_OE  <= 1'b0;
                        oPS2_DATA_OE <= 1'b1;
                        state_q      <= StStart;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end
                StStart: begin
                    bit_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    state_q   <= StXfer;
                end
                StXfer: begin
                    if (fe) begin
                        // Each falling edge presents the next bit; the shifted-in ones release DATA.
                        to_cnt_q     <= '0;
                        oPS2_DATA_OE <= ~shift_q[0];
                        shift_q      <= {1'b1, shift_q[9:1]};
                        bit_cnt_q    <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= StAck;
                        end
                    end else if (to_hit) begin
                        oPS2_DATA_OE <= 1'b0;
                        oERROR       <= 1'b1;
                        state_q      <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StAck: begin
                    if (fe) begin
                        to_cnt_q <= '0;
                        if (!iPS2_DATA) begin
                            ack_q   <= 1'b1;
                            state_q <= StWaitIdle;
                        end else begin
                            oPS2_DATA_OE <= 1'b0;
                            oERROR       <= 1'b1;
                            state_q      <= StError;
                        end
                    end else if (to_hit) begin
                        oPS2_DATA_OE <= 1'b0;
                        oERROR       <= 1'b1;
                        state_q      <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (ack_q && iPS2_CLK && iPS2_DATA) begin
                        oDONE   <= 1'b1;
                        state_q <= StDone;
                    end else if (fe) begin
                        to_cnt_q <= '0;
                    end else if (to_hit) begin
                        oERROR  <= 1'b1;
                        state_q <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    oDONE   <= 1'b0;
                    oBUSY   <= 1'b0;
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
                StError: begin
                    oERROR       <= 1'b0;
                    oBUSY        <= 1'b0;
                    ack_q        <= 1'b0;
                    oPS2_CLK_OE  <= 1'b0;
                    oPS2_DATA_OE <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard_transmitter.sv
// Bench for keyboard_transmitter: a PS/2 device model clocks frames, a scoreboard of expected
// frame bits is checked against the bits sampled on the line.
module tb_keyboard_transmitter;

    localparam int Inh  = 8;
    localparam int Tmo  = 100;
    localparam int Half = 4;

    logic       iCLOCK = 1'b0;
    logic       inRESET = 1'b0;
    logic       iRESET_SYNC = 1'b0;
    logic       iREQ = 1'b0;
    logic [7:0] iDATA = 8'h00;
    logic       oBUSY, oDONE, oERROR, oPS2_CLK_OE, oPS2_DATA_OE;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = dev_clk & ~oPS2_CLK_OE;
    assign ps2_data = dev_data & ~oPS2_DATA_OE;

    keyboard_transmitter #(
        .P_INHIBIT_CYCLES(Inh),
        .P_TIMEOUT_CYCLES(Tmo)
    ) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iREQ        (iREQ),
        .iDATA       (iDATA),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE),
        .oERROR      (oERROR),
        .iPS2_CLK    (ps2_clk),
        .iPS2_DATA   (ps2_data),
        .oPS2_CLK_OE (oPS2_CLK_OE),
        .oPS2_DATA_OE(oPS2_DATA_OE)
    );

    always #5 iCLOCK = ~iCLOCK;

    int checks = 0;
    int failures = 0;

    // Pulse monitor, sampled on the inactive edge.
    int   done_cnt = 0, err_cnt = 0, inh_total = 0, both_cnt = 0;
    logic err_oe = 1'b0, err_busy = 1'b0, done_busy = 1'b0, busy_after = 1'b1, pulse_d = 1'b0;
    always @(negedge iCLOCK) begin
        if (pulse_d) busy_after = oBUSY;
        if (oDONE) begin
            done_cnt++;
            done_busy = oBUSY;
        end
        if (oERROR) begin
            err_cnt++;
            err_oe   = oPS2_CLK_OE | oPS2_DATA_OE;
            err_busy = oBUSY;
        end
        if (oDONE && oERROR) both_cnt++;
        if (oPS2_CLK_OE) inh_total++;
        pulse_d = oDONE | oERROR;
    end

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic       parity;
        logic       exp_done;
    } vec_t;

    vec_t        vecs[5];
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic request(input logic [7:0] d, input logic par);
        tick();
        iREQ  = 1'b1;
        iDATA = d;
        tick();
        iREQ  = 1'b0;
        iDATA = ~d;
        exp_q.push_back({1'b1, par, d, 1'b0});
        check("busy_rise", oBUSY, 1);
    endtask

    task automatic wait_release();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!oPS2_CLK_OE && oPS2_DATA_OE) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("start_bit_driven", ok, 1);
    endtask

    task automatic device_clocks(input int n, input bit mid_req, output logic [10:0] bits);
        bits = '1;
        repeat (Half) tick();
        bits[0] = ps2_data;
        for (int i = 1; i <= n; i++) begin
            dev_clk = 1'b0;
            if (mid_req && i == 4) begin
                iREQ  = 1'b1;
                iDATA = 8'hFF;
            end
            repeat (Half) tick();
            iREQ    = 1'b0;
            dev_clk = 1'b1;
            bits[i] = ps2_data;
            repeat (Half) tick();
        end
    endtask

    task automatic device_ack(input logic nack);
        dev_data = nack;
        tick();
        dev_clk = 1'b0;
        repeat (Half) tick();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (Half) tick();
    endtask

    task automatic run_vec(input vec_t v, input bit mid_req);
        int          d0, e0, i0;
        logic [10:0] bits, exp;
        d0 = done_cnt;
        e0 = err_cnt;
        i0 = inh_total;
        request(v.data, v.parity);
        wait_release();
        device_clocks(10, mid_req, bits);
        device_ack(v.nack);
        repeat (4) tick();
        exp = exp_q.pop_front();
        check("frame_bits", bits, exp);
        check("inhibit_len", inh_total - i0, Inh);
        check("done_pulses", done_cnt - d0, v.exp_done ? 1 : 0);
        check("error_pulses", err_cnt - e0, v.exp_done ? 0 : 1);
        check("busy_end", oBUSY, 0);
        check("busy_after_pulse", busy_after, 0);
        check("oe_end", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        if (v.exp_done) check("busy_at_done", done_busy, 1);
        else begin
            check("oe_at_error", err_oe, 0);
            check("busy_at_error", err_busy, 1);
        end
    endtask

    initial begin
        logic [10:0] bits, exp;
        int          d0, e0, n;
        bit          found;

        vecs[0] = '{data: 8'hED, nack: 1'b0, parity: 1'b1, exp_done: 1'b1};
        vecs[1] = '{data: 8'h01, nack: 1'b0, parity: 1'b0, exp_done: 1'b1};
        vecs[2] = '{data: 8'h00, nack: 1'b0, parity: 1'b1, exp_done: 1'b1};
        vecs[3] = '{data: 8'hA5, nack: 1'b1, parity: 1'b1, exp_done: 1'b0};
        vecs[4] = '{data: 8'h3C, nack: 1'b0, parity: 1'b1, exp_done: 1'b1};

        repeat (3) tick();
        check("rst_busy", oBUSY, 0);
        check("rst_done", oDONE, 0);
        check("rst_error", oERROR, 0);
        check("rst_clk_oe", oPS2_CLK_OE, 0);
        check("rst_data_oe", oPS2_DATA_OE, 0);
        inRESET = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        // Second request mid-frame must be ignored.
        run_vec(vecs[0], 1'b1);
        repeat (20) tick();
        check("mid_req_ignored", oBUSY, 0);

        // Timeout: device stops clocking after the fourth falling edge.
        e0 = err_cnt;
        d0 = done_cnt;
        request(8'h5A, 1'b1);
        wait_release();
        device_clocks(3, 1'b0, bits);
        dev_clk = 1'b0;
        found = 1'b0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == Half - 1) dev_clk = 1'b1;
            if (oERROR) begin
                found = 1'b1;
                n = k;
                break;
            end
        end
        check("timeout_seen", found, 1);
        check("timeout_cycles", n, Tmo);
        check("timeout_oe", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        check("timeout_no_done", oDONE, 0);
        tick();
        check("timeout_busy_low", oBUSY, 0);
        exp = exp_q.pop_front();
        check("timeout_bits", bits[3:0], exp[3:0]);
        repeat (3) tick();
        check("timeout_err_count", err_cnt - e0, 1);
        check("timeout_done_count", done_cnt - d0, 0);
        run_vec(vecs[1], 1'b0);

        // Asynchronous reset during XFER.
        d0 = done_cnt;
        e0 = err_cnt;
        request(8'h00, 1'b1);
        wait_release();
        device_clocks(3, 1'b0, bits);
        check("pre_areset_data_oe", oPS2_DATA_OE, 1);
        #2 inRESET = 1'b0;
        #1;
        check("areset_oe", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        check("areset_busy", oBUSY, 0);
        tick();
        inRESET = 1'b1;
        device_clocks(7, 1'b0, bits);
        device_ack(1'b0);
        repeat (10) tick();
        check("areset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        void'(exp_q.pop_front());

        // Synchronous reset during XFER acts on the next edge.
        d0 = done_cnt;
        e0 = err_cnt;
        request(8'h00, 1'b1);
        wait_release();
        device_clocks(3, 1'b0, bits);
        iRESET_SYNC = 1'b1;
        #1;
        check("sreset_delayed", oPS2_DATA_OE, 1);
        tick();
        iRESET_SYNC = 1'b0;
        check("sreset_oe", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        check("sreset_busy", oBUSY, 0);
        device_clocks(7, 1'b0, bits);
        device_ack(1'b0);
        repeat (10) tick();
        check("sreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        void'(exp_q.pop_front());

        run_vec(vecs[4], 1'b0);
        check("done_error_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
